// File: rtl/jtgng_romrq_multi_if.sv
// Client/SDRAM-side bundle of the multi-entry ROM request cache.
// The cache uses the slave view; the client/arbiter side uses master.
interface jtgng_romrq_multi_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic          cen;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic          flush;
  logic [31:0]   din;
  logic          we;
  logic          req;
  logic [AW-1:0] addr_req;
  logic          data_ok;
  logic [DW-1:0] dout;

  modport master (
    output cen, addr, addr_ok, flush, din, we,
    input  req, addr_req, data_ok, dout
  );

  modport slave (
    input  cen, addr, addr_ok, flush, din, we,
    output req, addr_req, data_ok, dout
  );
endinterface

// File: rtl/jtgng_romrq_multi.sv
// Multi-entry ROM request cache: ENTRIES cached 32-bit words, round-robin
// replacement, one outstanding SDRAM fill at a time.
module jtgng_romrq_multi #(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int ENTRIES   = 4,
  parameter int INVERT_A0 = 0
) (
  input logic clk,
  input logic rst,
  jtgng_romrq_multi_if.slave bus
);
  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_reg;
  logic [ENTRIES-1:0] valid_reg;
  logic [AW-1:0]      tag_reg  [ENTRIES];
  logic [31:0]        data_reg [ENTRIES];
  logic [PW-1:0]      ptr_reg;
  logic               req_reg;
  logic               data_ok_reg;
  logic [AW-1:0]      addr_req_reg;
  logic [DW-1:0]      dout_reg;

  logic [AW-1:0]      aligned;
  logic [ENTRIES-1:0] match;
  logic [PW-1:0]      hit_idx;
  logic               hit;
  logic [31:0]        hit_word;
  logic [1:0]         sa;
  logic [DW-1:0]      lane;

  always_comb begin
    aligned = bus.addr;
    if (DW == 8)
      aligned[1:0] = 2'b00;
    else if (DW == 16)
      aligned[0] = 1'b0;
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (tag_reg[gi] == aligned);
  end

  // Lowest matching index wins if two entries ever carry the same tag.
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (match[i]) hit_idx = PW'(i);
  end

  assign hit      = bus.addr_ok && (|match);
  assign hit_word = data_reg[hit_idx];
  assign sa       = bus.addr[1:0] ^ {1'b0, (INVERT_A0 != 0) && (DW != 32)};

  if (DW == 8) begin : g_lane8
    assign lane = hit_word[{sa, 3'b000} +: 8];
  end else if (DW == 16) begin : g_lane16
    assign lane = sa[0] ? hit_word[31:16] : hit_word[15:0];
  end else begin : g_lane32
    assign lane = hit_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      valid_reg    <= '0;
      ptr_reg      <= '0;
      req_reg      <= 1'b0;
      data_ok_reg  <= 1'b0;
      addr_req_reg <= '0;
      dout_reg     <= '0;
    end else if (bus.flush) begin
      // Flush wins over cen, a pending fill and any coincident we.
      state_reg   <= IDLE;
      valid_reg   <= '0;
      ptr_reg     <= '0;
      req_reg     <= 1'b0;
      data_ok_reg <= 1'b0;
    end else if (bus.cen) begin
      case (state_reg)
        IDLE: begin
          addr_req_reg <= aligned;
          data_ok_reg  <= hit;
          if (hit)
            dout_reg <= lane;
          if (bus.addr_ok && !hit) begin
            state_reg <= WAIT;
            req_reg   <= 1'b1;
          end
        end
        WAIT: begin
          data_ok_reg <= 1'b0;
          // addr_req stays frozen here, so the fill is tagged with the
          // address that missed even if the client moved on.
          if (bus.we) begin
            tag_reg[ptr_reg]   <= addr_req_reg;
            data_reg[ptr_reg]  <= bus.din;
            valid_reg[ptr_reg] <= 1'b1;
            ptr_reg            <= ptr_reg + 1'b1;
            state_reg          <= IDLE;
            req_reg            <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req      = req_reg;
  assign bus.addr_req = addr_req_reg;
  assign bus.data_ok  = data_ok_reg;
  assign bus.dout     = dout_reg;
endmodule

// File: tb/tb_jtgng_romrq_multi.sv
// Self-checking bench: four cache builds (DW8, DW8 inverted A0, DW16, DW32)
// share one stimulus stream; a cache-level reference model predicts each.
module tb_jtgng_romrq_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [17:0] addr = '0;
  logic        addr_ok = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] din = '0;
  logic        we = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtgng_romrq_multi_if #(.AW(18), .DW(8))  i0 ();
  jtgng_romrq_multi_if #(.AW(18), .DW(8))  i1 ();
  jtgng_romrq_multi_if #(.AW(18), .DW(16)) i2 ();
  jtgng_romrq_multi_if #(.AW(18), .DW(32)) i3 ();

  assign i0.cen = cen; assign i0.addr = addr; assign i0.addr_ok = addr_ok;
  assign i0.flush = flush; assign i0.din = din; assign i0.we = we;
  assign i1.cen = cen; assign i1.addr = addr; assign i1.addr_ok = addr_ok;
  assign i1.flush = flush; assign i1.din = din; assign i1.we = we;
  assign i2.cen = cen; assign i2.addr = addr; assign i2.addr_ok = addr_ok;
  assign i2.flush = flush; assign i2.din = din; assign i2.we = we;
  assign i3.cen = cen; assign i3.addr = addr; assign i3.addr_ok = addr_ok;
  assign i3.flush = flush; assign i3.din = din; assign i3.we = we;

  jtgng_romrq_multi #(.AW(18), .DW(8),  .ENTRIES(4), .INVERT_A0(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  jtgng_romrq_multi #(.AW(18), .DW(8),  .ENTRIES(4), .INVERT_A0(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  jtgng_romrq_multi #(.AW(18), .DW(16), .ENTRIES(4), .INVERT_A0(0)) u2 (.clk(clk), .rst(rst), .bus(i2));
  jtgng_romrq_multi #(.AW(18), .DW(32), .ENTRIES(4), .INVERT_A0(0)) u3 (.clk(clk), .rst(rst), .bus(i3));

  // ---------------- reference model ----------------
  int          m_dw  [4] = '{8, 8, 16, 32};
  bit          m_inv [4] = '{0, 1, 0, 0};
  bit          m_valid [4][4];
  logic [17:0] m_tag   [4][4];
  logic [31:0] m_data  [4][4];
  int          m_ptr  [4];
  bit          m_wait [4];
  bit          m_dok  [4];
  logic [17:0] m_areq [4];
  logic [31:0] m_dout [4];

  function automatic logic [17:0] m_align(int k, logic [17:0] a);
    if (m_dw[k] == 8)  return a & ~18'h3;
    if (m_dw[k] == 16) return a & ~18'h1;
    return a;
  endfunction

  function automatic logic [31:0] m_lane(int k, logic [31:0] w, logic [17:0] a);
    int s;
    s = int'(a[1:0]);
    if (m_inv[k] && m_dw[k] != 32) s = s ^ 1;
    if (m_dw[k] == 8)  return (w >> (8 * s)) & 32'hFF;
    if (m_dw[k] == 16) return (w >> (16 * (s % 2))) & 32'hFFFF;
    return w;
  endfunction

  function automatic void model_step();
    logic [17:0] al;
    int idx;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        for (int e = 0; e < 4; e++) m_valid[k][e] = 1'b0;
        m_ptr[k] = 0; m_wait[k] = 1'b0; m_dok[k] = 1'b0;
        m_areq[k] = '0; m_dout[k] = '0;
      end else if (flush) begin
        for (int e = 0; e < 4; e++) m_valid[k][e] = 1'b0;
        m_ptr[k] = 0; m_wait[k] = 1'b0; m_dok[k] = 1'b0;
      end else if (cen) begin
        if (!m_wait[k]) begin
          al = m_align(k, addr);
          idx = -1;
          for (int e = 3; e >= 0; e--)
            if (m_valid[k][e] && m_tag[k][e] == al) idx = e;
          m_areq[k] = al;
          m_dok[k] = addr_ok && (idx >= 0);
          if (m_dok[k]) m_dout[k] = m_lane(k, m_data[k][idx], addr);
          if (addr_ok && idx < 0) m_wait[k] = 1'b1;
        end else begin
          m_dok[k] = 1'b0;
          if (we) begin
            m_tag[k][m_ptr[k]] = m_areq[k];
            m_data[k][m_ptr[k]] = din;
            m_valid[k][m_ptr[k]] = 1'b1;
            m_ptr[k] = (m_ptr[k] + 1) % 4;
            m_wait[k] = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic void dut_out(int k, output logic r, output logic [17:0] ar,
                                  output logic d, output logic [31:0] o);
    case (k)
      0: begin r = i0.req; ar = i0.addr_req; d = i0.data_ok; o = 32'(i0.dout); end
      1: begin r = i1.req; ar = i1.addr_req; d = i1.data_ok; o = 32'(i1.dout); end
      2: begin r = i2.req; ar = i2.addr_req; d = i2.data_ok; o = 32'(i2.dout); end
      default: begin r = i3.req; ar = i3.addr_req; d = i3.data_ok; o = i3.dout; end
    endcase
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_model();
    logic r, d;
    logic [17:0] ar;
    logic [31:0] o;
    for (int k = 0; k < 4; k++) begin
      dut_out(k, r, ar, d, o);
      chk($sformatf("model_req[%0d]", k), 32'(r), 32'(m_wait[k]));
      chk($sformatf("model_addr_req[%0d]", k), 32'(ar), 32'(m_areq[k]));
      chk($sformatf("model_data_ok[%0d]", k), 32'(d), 32'(m_dok[k]));
      chk($sformatf("model_dout[%0d]", k), o, m_dout[k]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(bit c, logic [17:0] a, bit ok, bit fl, bit w, logic [31:0] d);
    cen = c; addr = a; addr_ok = ok; flush = fl; we = w; din = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(logic [17:0] a, logic [31:0] d);
    drive(1, a, 1, 0, 0, 0);
    tick();
    drive(1, a, 1, 0, 1, d);
    tick();
    we = 1'b0;
    $display("fill addr=%h din=%h", a, d);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, cen, ok, fl, we;
    logic [17:0] a;
    logic [31:0] d;
    bit          req;
    logic [17:0] areq;
    bit          dok;
    logic [7:0]  q0, q1;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, logic [17:0] a, bit ok, bit fl, bit w,
                              logic [31:0] d, bit req, logic [17:0] areq, bit dok,
                              logic [7:0] q0, logic [7:0] q1);
    vec_t v;
    v.rst = r; v.cen = c; v.a = a; v.ok = ok; v.fl = fl; v.we = w; v.d = d;
    v.req = req; v.areq = areq; v.dok = dok; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    //           rst cen addr    ok fl we din           req areq    dok q0     q1
    tbl[0]  = mk(1, 1, 18'h00, 0, 0, 0, 32'h0,        0, 18'h00, 0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 1, 18'h12, 1, 0, 0, 32'h0,        1, 18'h10, 0, 8'h00, 8'h00);
    tbl[2]  = mk(0, 1, 18'h12, 1, 0, 1, 32'hDDCCBBAA, 0, 18'h10, 0, 8'h00, 8'h00);
    tbl[3]  = mk(0, 1, 18'h12, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hCC, 8'hDD);
    tbl[4]  = mk(0, 1, 18'h10, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hAA, 8'hBB);
    tbl[5]  = mk(0, 1, 18'h11, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hBB, 8'hAA);
    tbl[6]  = mk(0, 1, 18'h12, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hCC, 8'hDD);
    tbl[7]  = mk(0, 1, 18'h13, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hDD, 8'hCC);
    tbl[8]  = mk(0, 1, 18'h13, 0, 0, 0, 32'h0,        0, 18'h10, 0, 8'hDD, 8'hCC);
    tbl[9]  = mk(0, 0, 18'h40, 1, 0, 0, 32'h0,        0, 18'h10, 0, 8'hDD, 8'hCC);
    tbl[10] = mk(0, 1, 18'h11, 1, 0, 1, 32'h12345678, 0, 18'h10, 1, 8'hBB, 8'hAA);
    tbl[11] = mk(0, 1, 18'h13, 1, 0, 0, 32'h0,        0, 18'h10, 1, 8'hDD, 8'hCC);
    tbl[12] = mk(0, 1, 18'h10, 1, 1, 0, 32'h0,        0, 18'h10, 0, 8'hDD, 8'hCC);
    tbl[13] = mk(0, 1, 18'h10, 1, 0, 0, 32'h0,        1, 18'h10, 0, 8'hDD, 8'hCC);
  end

  initial begin
    #1;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].cen, tbl[i].a, tbl[i].ok, tbl[i].fl, tbl[i].we, tbl[i].d);
      tick();
      chk($sformatf("vec%0d_req", i), 32'(i0.req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_addr_req", i), 32'(i0.addr_req), 32'(tbl[i].areq));
      chk($sformatf("vec%0d_data_ok", i), 32'(i0.data_ok), 32'(tbl[i].dok));
      chk($sformatf("vec%0d_dout", i), 32'(i0.dout), 32'(tbl[i].q0));
      chk($sformatf("vec%0d_dout_inv", i), 32'(i1.dout), 32'(tbl[i].q1));
      $display("vec %0d addr=%h ok=%0b we=%0b flush=%0b -> req=%0b data_ok=%0b dout=%h/%h",
               i, tbl[i].a, tbl[i].ok, tbl[i].we, tbl[i].fl, i0.req, i0.data_ok, i0.dout, i1.dout);
    end
    rst = 1'b0;

    // Round-robin replacement: the fifth fill evicts the first one.
    do_reset();
    fill(18'h00, 32'hA3A2A1A0);
    fill(18'h04, 32'hB3B2B1B0);
    fill(18'h08, 32'hC3C2C1C0);
    fill(18'h0C, 32'hD3D2D1D0);
    fill(18'h10, 32'hE3E2E1E0);
    drive(1, 18'h04, 1, 0, 0, 0); tick();
    chk("rr_hit4_data_ok", 32'(i0.data_ok), 32'd1);
    chk("rr_hit4_dout", 32'(i0.dout), 32'hB0);
    chk("rr_hit4_req", 32'(i0.req), 32'd0);
    drive(1, 18'h00, 1, 0, 0, 0); tick();
    chk("rr_evicted0_req", 32'(i0.req), 32'd1);
    chk("rr_evicted0_addr_req", 32'(i0.addr_req), 32'h00);
    drive(1, 18'h00, 1, 0, 1, 32'hA3A2A1A0); tick();
    we = 1'b0;
    $display("round-robin sequence done");

    // Address change plus cen stall while a fill is pending.
    do_reset();
    drive(1, 18'h10, 1, 0, 0, 0); tick();
    chk("hold_req_start", 32'(i0.req), 32'd1);
    drive(0, 18'h40, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", 32'(i0.req), 32'd1);
      chk("hold_addr_req", 32'(i0.addr_req), 32'h10);
    end
    drive(1, 18'h40, 1, 0, 1, 32'h55667788); tick();
    chk("hold_fill_req", 32'(i0.req), 32'd0);
    drive(1, 18'h40, 1, 0, 0, 0); tick();
    chk("hold_new_miss_req", 32'(i0.req), 32'd1);
    chk("hold_new_miss_addr_req", 32'(i0.addr_req), 32'h40);
    drive(1, 18'h40, 1, 0, 1, 32'h99AABBCC); tick();
    drive(1, 18'h10, 1, 0, 0, 0); tick();
    chk("hold_tag10_data_ok", 32'(i0.data_ok), 32'd1);
    chk("hold_tag10_dout", 32'(i0.dout), 32'h88);
    $display("hold sequence done");

    // Flush colliding with a fill strobe.
    drive(1, 18'h80, 1, 0, 0, 0); tick();
    chk("flush_pre_req", 32'(i0.req), 32'd1);
    drive(1, 18'h80, 1, 1, 1, 32'h01020304); tick();
    chk("flush_req", 32'(i0.req), 32'd0);
    chk("flush_data_ok", 32'(i0.data_ok), 32'd0);
    drive(1, 18'h10, 1, 0, 0, 0); tick();
    chk("flush_old_miss_req", 32'(i0.req), 32'd1);
    drive(1, 18'h10, 1, 0, 1, 32'hCAFEF00D); tick();
    drive(1, 18'h10, 1, 0, 0, 0); tick();
    chk("flush_refill_dout", 32'(i0.dout), 32'h0D);
    $display("flush sequence done");

    // Wider builds and a spurious we in IDLE.
    do_reset();
    fill(18'h20, 32'h11112222);
    drive(1, 18'h20, 1, 0, 0, 0); tick();
    chk("dw16_lo_data_ok", 32'(i2.data_ok), 32'd1);
    chk("dw16_lo_dout", 32'(i2.dout), 32'h2222);
    chk("dw32_dout", i3.dout, 32'h11112222);
    drive(1, 18'h21, 1, 0, 0, 0); tick();
    chk("dw16_hi_dout", 32'(i2.dout), 32'h1111);
    drive(1, 18'h20, 1, 0, 1, 32'hFFFFFFFF); tick();
    drive(1, 18'h20, 1, 0, 0, 0); tick();
    chk("dw16_spurious_we_dout", 32'(i2.dout), 32'h2222);
    chk("dw16_spurious_we_req", 32'(i2.req), 32'd0);
    chk("dw32_after_we_dout", i3.dout, 32'h11112222);
    $display("dw16/dw32 sequence done");

    // Randomized traffic checked only against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, 18'($urandom_range(0, 47)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0, $urandom);
      tick();
    end
    rst = 1'b0;
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end
endmodule
